// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding, the fixed host byte mask
// and the packed write-side bundle that the memory mux selects between.
package mem_port_arbiter_pkg;

  typedef logic [0:0] arb_state_t;

  localparam arb_state_t ARB_IDLE    = 1'b0;
  localparam arb_state_t ARB_RD_HOLD = 1'b1;

  localparam logic [3:0] HOST_WSTRB = 4'hF;

  typedef struct packed {
    logic        wr;
    logic [31:0] wdat;
    logic [3:0]  strb;
  } mem_wr_t;

endpackage

// File: rtl/mem_port_arbiter_rd_buf.sv
// One-entry CPU read response buffer: loads in the fire cycle, valid from the next cycle.
// Holds data stable until rdy_i; clr_i (CPU reset) drops the entry.
module arb_rd_buf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [31:0] load_dat_i,
  input  logic        rdy_i,
  output logic [31:0] dat_o,
  output logic        vld_o
);

  logic [31:0] dat_q, dat_d;
  logic        vld_q, vld_d;

  always_comb begin
    dat_d = dat_q;
    vld_d = vld_q;
    if (clr_i) begin
      dat_d = 32'h0;
      vld_d = 1'b0;
    end else if (load_i) begin
      dat_d = load_dat_i;
      vld_d = 1'b1;
    end else if (vld_q && rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dat_q <= 32'h0;
      vld_q <= 1'b0;
    end else begin
      dat_q <= dat_d;
      vld_q <= vld_d;
    end
  end

  assign dat_o = dat_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port memory between host pulses (always win, zero latency) and the CPU
// ready/valid port (reads answered from a buffer at T+1). Optional ARB_PERF_CNT_EN adds counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  mips_rst,
  input  logic [ADDR_WIDTH-3:0] AXI_Address,
  input  logic                  AXI_MemWrite,
  input  logic                  AXI_MemRead,
  input  logic [31:0]           AXI_Write_data,
  output logic [31:0]           AXI_Read_data,
  input  logic [31:0]           Address,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [31:0]           Write_data,
  input  logic [3:0]            Write_strb,
  output logic                  Mem_Req_Ready,
  output logic [31:0]           Read_data,
  output logic                  Read_data_Valid,
  input  logic                  Read_data_Ready,
  output logic [ADDR_WIDTH-3:0] Mem_Address,
  output logic                  Mem_MemWrite,
  output logic [31:0]           Mem_Write_data,
  output logic [3:0]            Mem_Write_strb,
  input  logic [31:0]           Mem_Read_data
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]           conflict_cnt,
  output logic [31:0]           cpu_acc_cnt
`endif
);

  arb_state_t state_q, state_d;
  logic       host_req;
  logic       cpu_req;
  logic       req_rdy;
  logic       cpu_fire;
  logic       cpu_wr_fire;
  logic       cpu_rd_fire;
  mem_wr_t    host_wr, cpu_wr, mem_wr;
  logic       addr_unused;

  assign host_req    = AXI_MemWrite | AXI_MemRead;
  assign cpu_req     = MemRead | MemWrite;
  assign addr_unused = ^{Address[31:ADDR_WIDTH], Address[1:0]};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state_q <= ARB_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mips_rst) begin
      state_d = ARB_IDLE;
    end else begin
      case (state_q)
        ARB_IDLE:    if (cpu_rd_fire)     state_d = ARB_RD_HOLD;
        ARB_RD_HOLD: if (Read_data_Ready) state_d = ARB_IDLE;
        default:                          state_d = ARB_IDLE;
      endcase
    end
  end

  // A simultaneous read+write request is treated as a write; the read is dropped.
  always_comb begin
    req_rdy     = (state_q == ARB_IDLE) & ~mips_rst & ~host_req;
    cpu_fire    = req_rdy & cpu_req;
    cpu_wr_fire = cpu_fire & MemWrite;
    cpu_rd_fire = cpu_fire & MemRead & ~MemWrite;
  end

  assign Mem_Req_Ready = req_rdy;

  always_comb begin
    host_wr = '{wr: AXI_MemWrite, wdat: AXI_Write_data, strb: HOST_WSTRB};
    cpu_wr  = '{wr: cpu_wr_fire, wdat: Write_data, strb: Write_strb};
    mem_wr  = host_req ? host_wr : cpu_wr;
  end

  assign Mem_Address    = host_req ? AXI_Address : Address[ADDR_WIDTH-1:2];
  assign Mem_MemWrite   = mem_wr.wr;
  assign Mem_Write_data = mem_wr.wdat;
  assign Mem_Write_strb = mem_wr.strb;
  assign AXI_Read_data  = AXI_MemRead ? Mem_Read_data : 32'h0;

  arb_rd_buf u_rd_buf (
    .clk_i      (S_AXI_ACLK),
    .rst_ni     (S_AXI_ARESETN),
    .clr_i      (mips_rst),
    .load_i     (cpu_rd_fire),
    .load_dat_i (Mem_Read_data),
    .rdy_i      (Read_data_Ready),
    .dat_o      (Read_data),
    .vld_o      (Read_data_Valid)
  );

`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] cpu_acc_cnt_q, cpu_acc_cnt_d;

  // Conflict counter saturates so long runs stay meaningful; access counter wraps.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    cpu_acc_cnt_d  = cpu_acc_cnt_q;
    if (mips_rst) begin
      conflict_cnt_d = 32'h0;
      cpu_acc_cnt_d  = 32'h0;
    end else begin
      if (host_req && cpu_req && (conflict_cnt_q != 32'hFFFF_FFFF))
        conflict_cnt_d = conflict_cnt_q + 32'd1;
      if (cpu_fire)
        cpu_acc_cnt_d = cpu_acc_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      conflict_cnt_q <= 32'h0;
      cpu_acc_cnt_q  <= 32'h0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      cpu_acc_cnt_q  <= cpu_acc_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign cpu_acc_cnt  = cpu_acc_cnt_q;
`endif

endmodule
